shared_counters_ctrl: RTL

Initiator-side controller for the shared counter array. Accepts one client request at a time over a valid/ready handshake and drives the array's command, id, size and load inputs with the correct multi-cycle sequencing. Collects the array's combinational allocation result and its serial per-subcounter read stream, reassembled into one wide value. Returns a single response per request, held until the client accepts it.

---
 rtl/shared_counters_pkg.sv | 26 ++
 rtl/shared_counters_ctrl_if.sv | 32 +++
 rtl/shared_counters_ctrl_read_assembler.sv | 79 +++++++
 rtl/shared_counters_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/shared_counters_pkg.sv
// Shared counter array: common encodings and default geometry.
// Used by the initiator-side controller and the array itself.
package shared_counters_pkg;

    localparam int DEF_N  = 10;
    localparam int DEF_G  = 4;
    localparam int DEF_DW = 64;

    typedef enum logic [2:0] {
        CMD_IDLE         = 3'b000,
        CMD_INCREMENT    = 3'b001,
        CMD_NEW_COUNTER  = 3'b010,
        CMD_DEALLOCATION = 3'b011,
        CMD_LOAD         = 3'b100,
        CMD_READ         = 3'b101
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LOAD_SETTLE,
        ST_READ_COLLECT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/shared_counters_ctrl_if.sv
// Client-side request/response bundle of the counter controller.
// master = client, slave = controller.
interface shared_counters_ctrl_if #(
    parameter int N  = 10,
    parameter int DW = 64
);
    localparam int IW = $clog2(N);

    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [IW-1:0] req_id;
    logic [31:0]   req_size;
    logic [DW-1:0] req_data;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_ok;
    logic [IW:0]   rsp_id;
    logic [DW-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_id, req_size, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_ok, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_id, req_size, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_ok, rsp_id, rsp_data
    );

endinterface

// File: rtl/shared_counters_ctrl_read_assembler.sv
// Reassembles the array's serial subcounter read stream into one word.
// Flags the end of the stream (last, gap, full, or no-data timeout).
import shared_counters_pkg::*;

module read_assembler #(
    parameter int N  = DEF_N,
    parameter int G  = DEF_G,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          active,
    input  logic [G-1:0]  rdata,
    input  logic          rdata_valid,
    input  logic          rdata_last,
    output logic          done,
    output logic          ok,
    output logic [DW-1:0] data
);

    localparam int BW = $clog2(N + 1);
    localparam logic [BW-1:0] B_LAST = BW'(N - 1);
    localparam logic [BW-1:0] T_MAX  = BW'(N);

    logic [BW-1:0] beats;
    logic [BW-1:0] idle;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_nxt;

    // Accumulator with the current beat merged into its slice.
    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < N; i++) begin
            if (rdata_valid && beats == BW'(i)) begin
                acc_nxt[i*G +: G] = rdata;
            end
        end
    end

    // Termination: last beat, stream gap, array full, or silent timeout.
    always_comb begin
        done = 1'b0;
        ok   = 1'b0;
        if (active) begin
            if (rdata_valid) begin
                if (rdata_last || beats == B_LAST) begin
                    done = 1'b1;
                    ok   = 1'b1;
                end
            end else if (beats != '0) begin
                done = 1'b1;
                ok   = 1'b1;
            end else if (idle == T_MAX) begin
                done = 1'b1;
            end
        end
    end

    assign data = acc_nxt;

    // Beat/idle counters and accumulator; cleared whenever not collecting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beats <= '0;
            idle  <= '0;
            acc   <= '0;
        end else if (!active) begin
            beats <= '0;
            idle  <= '0;
            acc   <= '0;
        end else if (rdata_valid) begin
            acc   <= acc_nxt;
            beats <= beats + BW'(1);
        end else if (beats == '0) begin
            idle  <= idle + BW'(1);
        end
    end

endmodule

// File: rtl/shared_counters_ctrl.sv
// Initiator-side controller for the shared counter array.
// One request in flight; sequences array commands and returns one response.
import shared_counters_pkg::*;

module shared_counters_ctrl #(
    parameter int N  = DEF_N,
    parameter int G  = DEF_G,
    parameter int DW = DEF_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    shared_counters_ctrl_if.slave  cl,
    output logic [2:0]             cmd_out,
    output logic [$clog2(N)-1:0]   id_out,
    output logic [31:0]            size_out,
    output logic [DW-1:0]          load_data_out,
    output logic                   load_valid_out,
    input  logic [$clog2(N):0]     alloc_id_in,
    input  logic                   alloc_valid_in,
    input  logic [G-1:0]           rdata_in,
    input  logic                   rdata_valid_in,
    input  logic                   rdata_last_in
);

    state_e        state;
    cmd_e          op_q;
    logic          bad;
    logic          rd_active;
    logic          rd_done;
    logic          rd_ok;
    logic [DW-1:0] rd_data;

    assign cl.req_ready = (state == ST_IDLE);
    assign rd_active    = (state == ST_READ_COLLECT);

    // Requests that never reach the array: bad op, bad id, bad alloc size.
    always_comb begin
        bad = 1'b0;
        unique case (cl.req_op)
            CMD_INCREMENT, CMD_DEALLOCATION, CMD_LOAD, CMD_READ: bad = 1'b0;
            CMD_NEW_COUNTER:
                bad = (cl.req_size == '0) || (cl.req_size > 32'(N));
            default: bad = 1'b1;
        endcase
        if (int'(cl.req_id) >= N) begin
            bad = 1'b1;
        end
    end

    read_assembler #(
        .N  (N),
        .G  (G),
        .DW (DW)
    ) u_rd (
        .clk         (clk),
        .rst         (rst),
        .active      (rd_active),
        .rdata       (rdata_in),
        .rdata_valid (rdata_valid_in),
        .rdata_last  (rdata_last_in),
        .done        (rd_done),
        .ok          (rd_ok),
        .data        (rd_data)
    );

    // Control FSM with registered array-side and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            op_q           <= CMD_IDLE;
            cmd_out        <= CMD_IDLE;
            id_out         <= '0;
            size_out       <= '0;
            load_data_out  <= '0;
            load_valid_out <= 1'b0;
            cl.rsp_valid   <= 1'b0;
            cl.rsp_ok      <= 1'b0;
            cl.rsp_id      <= '0;
            cl.rsp_data    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cl.req_valid) begin
                        if (bad) begin
                            cl.rsp_valid <= 1'b1;
                            cl.rsp_ok    <= 1'b0;
                            state        <= ST_RESP;
                        end else begin
                            op_q     <= cmd_e'(cl.req_op);
                            cmd_out  <= cl.req_op;
                            id_out   <= cl.req_id;
                            size_out <= cl.req_size;
                            if (cl.req_op == CMD_LOAD) begin
                                load_valid_out <= 1'b1;
                                load_data_out  <= cl.req_data;
                            end
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    load_valid_out <= 1'b0;
                    load_data_out  <= '0;
                    unique case (op_q)
                        CMD_NEW_COUNTER: begin
                            cmd_out      <= CMD_IDLE;
                            cl.rsp_ok    <= alloc_valid_in;
                            cl.rsp_id    <= alloc_id_in;
                            cl.rsp_valid <= 1'b1;
                            state        <= ST_RESP;
                        end
                        CMD_LOAD: begin
                            cmd_out <= CMD_IDLE;
                            state   <= ST_LOAD_SETTLE;
                        end
                        CMD_READ: begin
                            cmd_out <= CMD_READ;
                            state   <= ST_READ_COLLECT;
                        end
                        default: begin
                            cmd_out      <= CMD_IDLE;
                            cl.rsp_ok    <= 1'b1;
                            cl.rsp_valid <= 1'b1;
                            state        <= ST_RESP;
                        end
                    endcase
                end
                ST_LOAD_SETTLE: begin
                    cl.rsp_ok    <= 1'b1;
                    cl.rsp_valid <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_READ_COLLECT: begin
                    if (rd_done) begin
                        cmd_out      <= CMD_IDLE;
                        cl.rsp_ok    <= rd_ok;
                        cl.rsp_data  <= rd_data;
                        cl.rsp_valid <= 1'b1;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (cl.rsp_ready) begin
                        cl.rsp_valid <= 1'b0;
                        cl.rsp_ok    <= 1'b0;
                        cl.rsp_id    <= '0;
                        cl.rsp_data  <= '0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
